stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Parametrised successor to the fixed MM:SS stopwatch counter.
- Counts up (stopwatch) or down (countdown timer) in minutes/seconds on a 1 Hz tick enable.
- Supports pause/resume, field adjust, a countdown preset and expiry.
- Sits between the clock-enable generator and debouncers (upstream) and the display mux (downstream).
- Single clock domain: all slow rates arrive as one-cycle enables on clk, never as derived clocks.

Parameters:
- MAX_MIN, 59, highest minutes value (up to 99 for display builds).
- MIN_W, $clog2(MAX_MIN+1), minutes field width (derived; do not override).
- WRAP_UP, 1, up-count at MAX_MIN:59: 1 = wrap to 0:00, 0 = saturate and hold.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle count enable.
- tick_adj  in  1  one-cycle adjust-rate enable (2 Hz).
- start_stop  in  1  one-cycle pulse from a debounced rising edge.
- clear  in  1  one-cycle synchronous clear pulse.
- adj  in  1  level: adjust mode request.
- sel  in  1  level: 0 = adjust minutes, 1 = adjust seconds.
- count_down  in  1  level: mode request, sampled only in IDLE.
- minutes  out  MIN_W  current minutes.
- seconds  out  6  current seconds.
- running  out  1  state == RUN.
- paused  out  1  state == PAUSED.
- adjusting  out  1  state == ADJUST.
- expired  out  1  state == EXPIRED.

Behaviour:
- Reset values: minutes=0, seconds=0, preset=0:00, mode=up, state=IDLE, all flags 0. All outputs are registered and change one cycle after the causing input.
- Input priority in a cycle: clear > adj > start_stop > tick_1hz.
- IDLE:
  - mode register loads count_down every cycle.
  - adj=1 -> ADJUST.
  - start_stop -> RUN, except in down mode with count 0:00, where the pulse is ignored.
- RUN:
  - Each tick_1hz steps the count by one.
  - Up: sec 59 -> 0 carries into minutes; at MAX_MIN:59, WRAP_UP selects 0:00 or hold.
  - Down: sec 0 -> 59 borrows from minutes; the step that reaches 0:00 also enters EXPIRED in the same cycle.
  - start_stop -> PAUSED. If tick and start_stop coincide, the tick is applied and the state moves to PAUSED.
  - adj is ignored in RUN.
- PAUSED:
  - Count held.
  - start_stop -> RUN.
  - adj=1 -> ADJUST.
- ADJUST:
  - tick_1hz ignored.
  - Each tick_adj increments the field chosen by sel, with no carry: seconds 59 -> 0, minutes MAX_MIN -> 0.
  - sel may change freely.
  - adj=0 -> IDLE; the same edge latches preset <= current count.
- EXPIRED:
  - Count held at 0:00, expired=1.
  - start_stop -> IDLE (acknowledge); count reloads preset.
- clear, from any state:
  - Count becomes 0:00 in up mode, preset in down mode.
  - State goes to IDLE; if adj is still high, ADJUST is entered the next cycle.
- Reset asserted mid-operation returns to reset values immediately. Deassertion is assumed synchronised upstream.
- minutes never exceeds MAX_MIN; seconds never exceeds 59 under any input sequence.

Optional Feature:
- Macro STOPWATCH_LAP_EN.
- Defined:
  - Adds input lap (one-cycle pulse) and outputs lap_min [MIN_W], lap_sec [6], lap_valid [1].
  - lap in RUN captures the count as it stands after any same-cycle tick and sets lap_valid.
  - lap in any other state is ignored.
  - clear or reset zeroes lap_min/lap_sec and lap_valid.
  - A second lap overwrites the capture.
- Undefined: no lap port or lap logic; the remaining interface and behaviour are unchanged.

Decomposition:
- Package stopwatch_pkg:
  - state enum IDLE/RUN/PAUSED/ADJUST/EXPIRED (3-bit).
  - SEC_MAX=59.
  - SEC_W=6.
- Sub-module time_field_counter, instantiated twice (seconds, minutes).
  - Parameters: MAX, W.
  - Inputs: inc, dec, clr, load and load value.
  - Outputs: value, carry_out at MAX on inc, borrow_out at 0 on dec.
- The core owns the FSM, mode register, preset register and carry chaining.

Test Plan:
- Reset, start_stop, 61 tick_1hz -> minutes=1, seconds=1, running=1; start_stop -> paused=1; 5 more ticks -> count unchanged at 1:01.
- Up mode, MAX_MIN=59, count driven to 59:59, one tick -> 0:00 with WRAP_UP=1; with WRAP_UP=0 the count holds at 59:59.
- Adjust preset:
  - adj=1, sel=0, 2 tick_adj -> 2:00; sel=1, 3 tick_adj -> 2:03; adj=0 -> IDLE.
  - count_down=1, start_stop, 123 ticks -> 0:00 with expired=1; further ticks keep 0:00.
- In EXPIRED, start_stop -> IDLE and count 2:03 (preset); clear in down mode -> 2:03; clear in up mode -> 0:00.
- Coincidence and priority:
  - In RUN at 0:10 up, tick and start_stop in the same cycle -> 0:11 and PAUSED.
  - clear with adj held -> IDLE then ADJUST next cycle, count 0:00.
- rst_n low mid-RUN at 3:07 -> all outputs 0 asynchronously. With STOPWATCH_LAP_EN, lap at 0:42 -> lap_sec=42, lap_valid=1, and the count continues.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch core: FSM state encoding and the
//   seconds field limits.
//   Optional feature macro used by the core: STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        ADJUST  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int SEC_W   = 6;

endpackage

// File: rtl/stopwatch_core_field.sv
// time_field_counter
//   One modulo-(MAX+1) time field (seconds or minutes) with increment,
//   decrement, clear and load. Increment at MAX wraps to 0, decrement at 0
//   wraps to MAX; the caller decides whether to chain or suppress.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   inc, dec        step enables (inc wins if both)
//   clr             synchronous clear to 0 (highest priority)
//   load, load_val  synchronous load (clamped to MAX)
//   value           registered field value
//   value_next      value the field takes at the next edge
//   carry_out       inc applied while value == MAX
//   borrow_out      dec applied while value == 0
module time_field_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic [W-1:0] value_next,
    output logic         carry_out,
    output logic         borrow_out
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic step_ok;

    // Steps only count when neither clear nor load overrides them.
    assign step_ok    = !clr && !load;
    assign carry_out  = step_ok && inc && (value == MAX_V);
    assign borrow_out = step_ok && !inc && dec && (value == '0);

    always_comb begin
        value_next = value;
        if (clr) begin
            value_next = '0;
        end else if (load) begin
            value_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (inc) begin
            value_next = (value == MAX_V) ? '0 : value + W'(1);
        end else if (dec) begin
            value_next = (value == '0) ? MAX_V : value - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   MM:SS stopwatch / countdown timer driven by one-cycle enables on clk.
//   Owns the FSM, mode register, preset register and seconds->minutes
//   carry/borrow chaining; the two fields are time_field_counter instances.
//   Optional feature macro: STOPWATCH_LAP_EN (adds lap capture).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tick_1hz       count enable
//   tick_adj       adjust-rate enable
//   start_stop     start/pause/resume/acknowledge pulse
//   clear          synchronous clear pulse
//   adj, sel       adjust request level, field select (0 min, 1 sec)
//   count_down     direction request, sampled in IDLE
//   minutes, seconds   current count
//   running, paused, adjusting, expired   registered state flags
//   lap, lap_min, lap_sec, lap_valid      lap capture (STOPWATCH_LAP_EN)
//
// Handshake: every control input is a single-cycle enable or a level; there
// is no back-pressure, each pulse is consumed in the cycle it is seen.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59,
    parameter int MIN_W   = $clog2(MAX_MIN + 1),
    parameter int WRAP_UP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             tick_adj,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             adj,
    input  logic             sel,
    input  logic             count_down,
`ifdef STOPWATCH_LAP_EN
    input  logic             lap,
    output logic [MIN_W-1:0] lap_min,
    output logic [SEC_W-1:0] lap_sec,
    output logic             lap_valid,
`endif
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             paused,
    output logic             adjusting,
    output logic             expired
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
    localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);

    state_t state;
    state_t state_next;

    logic             mode_down;
    logic [MIN_W-1:0] preset_min;
    logic [SEC_W-1:0] preset_sec;

    logic             down;
    logic             zero;
    logic             at_max;

    logic             sec_inc, sec_dec, min_dec_en, adj_min_inc, min_inc;
    logic             cnt_clr, cnt_load;
    logic             sec_carry, sec_borrow;
    logic [MIN_W-1:0] min_next;
    logic [SEC_W-1:0] sec_next;
    logic             min_carry, min_borrow;

    // In IDLE the mode register is still tracking the request, so the live
    // input is the direction that will take effect on this edge.
    assign down   = (state == IDLE) ? count_down : mode_down;
    assign zero   = (minutes == '0) && (seconds == '0);
    assign at_max = (minutes == MAX_MIN_V) && (seconds == SEC_MAX_V);

    // Field controls for this cycle.
    always_comb begin
        sec_inc     = 1'b0;
        sec_dec     = 1'b0;
        adj_min_inc = 1'b0;
        cnt_clr     = 1'b0;
        cnt_load    = 1'b0;
        if (clear) begin
            if (down) begin
                cnt_load = 1'b1;
            end else begin
                cnt_clr = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (tick_1hz) begin
                        if (!down) begin
                            // WRAP_UP == 0 freezes the count at MAX_MIN:59.
                            if (!(at_max && (WRAP_UP == 0))) begin
                                sec_inc = 1'b1;
                            end
                        end else if (!zero) begin
                            sec_dec = 1'b1;
                        end
                    end
                end
                ADJUST: begin
                    if (tick_adj) begin
                        if (sel) begin
                            sec_inc = 1'b1;
                        end else begin
                            adj_min_inc = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (start_stop) begin
                        cnt_load = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Chaining only while counting; in ADJUST a seconds wrap must not carry.
    assign min_inc    = adj_min_inc || ((state == RUN) && sec_carry);
    assign min_dec_en = (state == RUN) && sec_borrow;

    time_field_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (sec_inc),
        .dec        (sec_dec),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .load_val   (preset_sec),
        .value      (seconds),
        .value_next (sec_next),
        .carry_out  (sec_carry),
        .borrow_out (sec_borrow)
    );

    time_field_counter #(.MAX(MAX_MIN), .W(MIN_W)) u_min (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (min_inc),
        .dec        (min_dec_en),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .load_val   (preset_min),
        .value      (minutes),
        .value_next (min_next),
        .carry_out  (min_carry),
        .borrow_out (min_borrow)
    );

    // Minutes carry/borrow have no further field to feed.
    logic unused_min_flags;
    assign unused_min_flags = min_carry ^ min_borrow;

    // Next-state decode. A down step landing on 0:00 expires in the same
    // cycle, even when start_stop coincides.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (adj) begin
                        state_next = ADJUST;
                    end else if (start_stop && !(count_down && zero)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (sec_dec && (min_next == '0) && (sec_next == '0)) begin
                        state_next = EXPIRED;
                    end else if (start_stop) begin
                        state_next = PAUSED;
                    end
                end
                PAUSED: begin
                    if (adj) begin
                        state_next = ADJUST;
                    end else if (start_stop) begin
                        state_next = RUN;
                    end
                end
                ADJUST: begin
                    if (!adj) begin
                        state_next = IDLE;
                    end
                end
                EXPIRED: begin
                    if (start_stop) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FSM register with registered state flags, mode and preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_down  <= 1'b0;
            preset_min <= '0;
            preset_sec <= '0;
            running    <= 1'b0;
            paused     <= 1'b0;
            adjusting  <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state     <= state_next;
            running   <= (state_next == RUN);
            paused    <= (state_next == PAUSED);
            adjusting <= (state_next == ADJUST);
            expired   <= (state_next == EXPIRED);
            if (state == IDLE) begin
                mode_down <= count_down;
            end
            // Leaving ADJUST commits the adjusted count as the preset.
            if (!clear && (state == ADJUST) && !adj) begin
                preset_min <= minutes;
                preset_sec <= seconds;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap captures the post-tick count, so use the fields' next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_min   <= '0;
            lap_sec   <= '0;
            lap_valid <= 1'b0;
        end else if (clear) begin
            lap_min   <= '0;
            lap_sec   <= '0;
            lap_valid <= 1'b0;
        end else if (lap && (state == RUN)) begin
            lap_min   <= min_next;
            lap_sec   <= sec_next;
            lap_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
//   Directed bench for stopwatch_core. A second instance with WRAP_UP=0
//   shares all inputs and is checked at reset and at the up-count limit.
//   Compile with +define+STOPWATCH_LAP_EN to include lap checks.
module tb_stopwatch_core;

    logic clk;
    logic rst_n;
    logic tick_1hz, tick_adj, start_stop, clear, adj, sel, count_down;
    logic [5:0] minutes, seconds, minutes_b, seconds_b;
    logic running, paused, adjusting, expired;
    logic running_b, paused_b, adjusting_b, expired_b;
`ifdef STOPWATCH_LAP_EN
    logic lap;
    logic [5:0] lap_min, lap_sec, lap_min_b, lap_sec_b;
    logic lap_valid, lap_valid_b;
`endif

    int vectors = 0;
    int errors  = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stopwatch_core #(.MAX_MIN(59), .WRAP_UP(1)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .start_stop(start_stop), .clear(clear), .adj(adj), .sel(sel),
        .count_down(count_down),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid),
`endif
        .minutes(minutes), .seconds(seconds), .running(running),
        .paused(paused), .adjusting(adjusting), .expired(expired)
    );

    stopwatch_core #(.MAX_MIN(59), .WRAP_UP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .start_stop(start_stop), .clear(clear), .adj(adj), .sel(sel),
        .count_down(count_down),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lap_min(lap_min_b), .lap_sec(lap_sec_b), .lap_valid(lap_valid_b),
`endif
        .minutes(minutes_b), .seconds(seconds_b), .running(running_b),
        .paused(paused_b), .adjusting(adjusting_b), .expired(expired_b)
    );

    // scoreboard helpers: count as MM*100+SS, flags as {run,pause,adj,exp}
    function automatic int cnt_a();
        return int'(minutes) * 100 + int'(seconds);
    endfunction

    function automatic int cnt_b();
        return int'(minutes_b) * 100 + int'(seconds_b);
    endfunction

    function automatic int flg_a();
        return int'({running, paused, adjusting, expired});
    endfunction

    function automatic int flg_b();
        return int'({running_b, paused_b, adjusting_b, expired_b});
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // driver tasks: inputs change 1 time unit after a rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_1hz = 1'b1;
        cyc(n);
        tick_1hz = 1'b0;
    endtask

    task automatic adj_ticks(input logic field_sel, input int n);
        sel      = field_sel;
        tick_adj = 1'b1;
        cyc(n);
        tick_adj = 1'b0;
    endtask

    localparam int F_IDLE = 0;
    localparam int F_RUN  = 8;
    localparam int F_PAU  = 4;
    localparam int F_ADJ  = 2;
    localparam int F_EXP  = 1;

    initial begin
        rst_n = 1'b0;
        tick_1hz = 1'b0; tick_adj = 1'b0; start_stop = 1'b0; clear = 1'b0;
        adj = 1'b0; sel = 1'b0; count_down = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        cyc(3);
        chk("reset_count", cnt_a(), 0);
        chk("reset_flags", flg_a(), F_IDLE);
        chk("reset_count_sat", cnt_b(), 0);
        chk("reset_flags_sat", flg_b(), F_IDLE);
`ifdef STOPWATCH_LAP_EN
        chk("reset_lap", int'({lap_valid, lap_min, lap_sec}), 0);
        chk("reset_lap_sat", int'({lap_valid_b, lap_min_b, lap_sec_b}), 0);
`endif
        rst_n = 1'b1;
        cyc(1);

        // basic up count, pause holds the count
        pulse_start();
        chk("start_run", flg_a(), F_RUN);
        ticks(61);
        chk("up_61", cnt_a(), 101);
        chk("up_61_flags", flg_a(), F_RUN);
        pulse_start();
        chk("pause_flags", flg_a(), F_PAU);
        ticks(5);
        chk("pause_hold", cnt_a(), 101);
        pulse_clear();
        chk("clear_up_count", cnt_a(), 0);
        chk("clear_up_flags", flg_a(), F_IDLE);

        // adjust to 59:59 (seconds wrap without carry), then the up limit
        adj = 1'b1;
        cyc(1);
        chk("adjust_enter", flg_a(), F_ADJ);
        adj_ticks(1'b0, 59);
        chk("adj_min59", cnt_a(), 5900);
        adj_ticks(1'b1, 60);
        chk("adj_sec_wrap_nocarry", cnt_a(), 5900);
        ticks(3);
        chk("adj_ignores_tick", cnt_a(), 5900);
        adj_ticks(1'b1, 59);
        chk("adj_5959", cnt_a(), 5959);
        adj = 1'b0;
        cyc(1);
        chk("adjust_exit", flg_a(), F_IDLE);
        pulse_start();
        ticks(1);
        chk("wrap_up", cnt_a(), 0);
        chk("sat_hold", cnt_b(), 5959);
        chk("sat_running", flg_b(), F_RUN);
        pulse_start();
        pulse_clear();
        chk("clear_after_wrap", cnt_a(), 0);
        chk("clear_after_sat", cnt_b(), 0);

        // preset 2:03 and countdown to expiry
        adj = 1'b1;
        cyc(1);
        adj_ticks(1'b0, 2);
        chk("adj_200", cnt_a(), 200);
        adj_ticks(1'b1, 3);
        chk("adj_203", cnt_a(), 203);
        adj = 1'b0;
        cyc(1);
        chk("preset_idle", flg_a(), F_IDLE);
        count_down = 1'b1;
        cyc(1);
        pulse_start();
        chk("down_run", flg_a(), F_RUN);
        ticks(122);
        chk("down_001", cnt_a(), 1);
        chk("down_001_flags", flg_a(), F_RUN);
        ticks(1);
        chk("expire_count", cnt_a(), 0);
        chk("expire_flags", flg_a(), F_EXP);
        ticks(3);
        chk("expired_hold", cnt_a(), 0);
        pulse_start();
        chk("ack_flags", flg_a(), F_IDLE);
        chk("ack_reload", cnt_a(), 203);
        pulse_clear();
        chk("clear_down", cnt_a(), 203);
        count_down = 1'b0;
        cyc(1);
        pulse_clear();
        chk("clear_up", cnt_a(), 0);
        count_down = 1'b1;
        cyc(1);
        pulse_start();
        chk("down_zero_start_ignored", flg_a(), F_IDLE);
        count_down = 1'b0;
        cyc(1);

        // tick coinciding with start_stop
        pulse_start();
        ticks(10);
        chk("run_010", cnt_a(), 10);
        tick_1hz = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        start_stop = 1'b0;
        chk("coincide_count", cnt_a(), 11);
        chk("coincide_flags", flg_a(), F_PAU);

        // clear beats adj; ADJUST follows one cycle later
        adj = 1'b1;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clear_adj_idle", flg_a(), F_IDLE);
        chk("clear_adj_count", cnt_a(), 0);
        cyc(1);
        chk("clear_adj_then_adjust", flg_a(), F_ADJ);
        adj = 1'b0;
        cyc(1);

        // lap at 0:42, then run on to 3:07 and reset asynchronously
        pulse_start();
`ifdef STOPWATCH_LAP_EN
        tick_1hz = 1'b1;
        cyc(41);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        tick_1hz = 1'b0;
        chk("lap_capture", int'({lap_valid, lap_min, lap_sec}), (1 << 12) | 42);
        ticks(3);
        chk("lap_run_continues", cnt_a(), 45);
        chk("lap_held", int'({lap_valid, lap_min, lap_sec}), (1 << 12) | 42);
        ticks(142);
`else
        ticks(187);
`endif
        chk("run_307", cnt_a(), 307);
        chk("run_307_flags", flg_a(), F_RUN);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", cnt_a(), 0);
        chk("async_reset_flags", flg_a(), F_IDLE);
`ifdef STOPWATCH_LAP_EN
        chk("async_reset_lap", int'({lap_valid, lap_min, lap_sec}), 0);
`endif
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
